// File: rtl/pc_seq_ctrl_pkg.sv
// Shared definitions for the next-PC sequencer, PC register and fetch logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding and the default address width / sequential increment.
package pc_seq_ctrl_pkg;

  localparam int PC_ADDR_W = 16;  // width of PC and redirect targets
  localparam int PC_INC    = 2;   // bytes per 16-bit instruction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STALL  = 2'd2,
    ST_HALTED = 2'd3
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry buffer that holds one redirect target captured while the PC is stalled.
// Latency: capture visible on pend_vld_o/pend_addr_o one cycle after capture_i.
// Backpressure: entry is occupied until clear_i; captures while occupied are dropped (first one wins).
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   capture_i/addr_i  store addr_i if the buffer is empty
//   clear_i           empty the buffer (consume on release, or discard on halt)
//   pend_vld_o        a redirect is buffered
//   pend_addr_o       buffered redirect target
module pc_redirect_buf
  import pc_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = PC_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              capture_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              clear_i,
  output logic              pend_vld_o,
  output logic [ADDR_W-1:0] pend_addr_o
);

  logic              pend_vld_q;
  logic [ADDR_W-1:0] pend_addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
    end else if (clear_i) begin
      pend_vld_q  <= 1'b0;
    end else if (capture_i && !pend_vld_q) begin
      // Only an empty buffer accepts a target; later redirects in the same stall are ignored.
      pend_vld_q  <= 1'b1;
      pend_addr_q <= addr_i;
    end
  end

  assign pend_vld_o  = pend_vld_q;
  assign pend_addr_o = pend_addr_q;

endmodule

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: picks increment / branch / jump each cycle and drives the PC register write port.
// Latency: zero; pc_in/pc_write are combinational and captured by the PC register on the same edge.
// Backpressure: stall freezes the PC and buffers one redirect; halt freezes it until reset.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start                         leave IDLE and begin sequencing
//   stall, halt                   hold PC this cycle / stop until reset
//   br_taken, br_target           resolved taken branch and its destination
//   jmp, jmp_target               unconditional jump and its destination
//   pc_out                        current PC register value
//   pc_in, pc_write               next PC and write enable to the PC register
//   flush                         one-cycle pulse the cycle after a redirect write
//   redirect_pending              a redirect is buffered during stall
//   state                         0 IDLE, 1 RUN, 2 STALL, 3 HALTED
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = PC_ADDR_W,
  parameter int INC    = PC_INC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              halt,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_in,
  output logic              pc_write,
  output logic              flush,
  output logic              redirect_pending,
  output logic [1:0]        state
);

  localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);

  pc_state_e         state_q, state_d;
  logic              flush_q, flush_d;

  logic              buf_capture;
  logic              buf_clear;
  logic [ADDR_W-1:0] buf_addr;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_addr;

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .capture_i   (buf_capture),
    .addr_i      (buf_addr),
    .clear_i     (buf_clear),
    .pend_vld_o  (pend_vld),
    .pend_addr_o (pend_addr)
  );

  // Jump outranks branch whenever both are presented, for both direct and buffered redirects.
  assign buf_addr = jmp ? jmp_target : br_target;

  always_comb begin
    state_d     = state_q;
    flush_d     = 1'b0;
    pc_write    = 1'b0;
    pc_in       = '0;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end

      ST_RUN, ST_STALL: begin
        if (halt && !stall) begin
          // A buffered redirect is meaningless once sequencing stops.
          state_d   = ST_HALTED;
          buf_clear = 1'b1;
        end else if (stall) begin
          // halt is deliberately ignored here; it only takes effect once stall drops.
          state_d     = ST_STALL;
          buf_capture = jmp || br_taken;
        end else begin
          state_d  = ST_RUN;
          pc_write = 1'b1;
          if (pend_vld) begin
            // Buffered redirect is older than anything arriving now, so it wins.
            pc_in     = pend_addr;
            buf_clear = 1'b1;
            flush_d   = 1'b1;
          end else if (jmp || br_taken) begin
            pc_in   = buf_addr;
            flush_d = 1'b1;
          end else begin
            pc_in = pc_out + INC_W;  // wraps modulo 2^ADDR_W
          end
        end
      end

      ST_HALTED: begin
        state_d = ST_HALTED;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  assign flush            = flush_q;
  assign redirect_pending = pend_vld;
  assign state            = state_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios followed by randomized episodes,
// compared against a behavioural model that also plays the external PC register.
module tb_pc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stall = 1'b0, halt = 1'b0, br_taken = 1'b0, jmp = 1'b0;
  logic [15:0] br_target = '0, jmp_target = '0;
  logic [15:0] pc_out;
  logic [15:0] pc_in;
  logic        pc_write, flush, redirect_pending;
  logic [1:0]  state;

  always #5 clk = ~clk;

  pc_seq_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .stall            (stall),
    .halt             (halt),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .jmp              (jmp),
    .jmp_target       (jmp_target),
    .pc_out           (pc_out),
    .pc_in            (pc_in),
    .pc_write         (pc_write),
    .flush            (flush),
    .redirect_pending (redirect_pending),
    .state            (state)
  );

  // Model state: mode 0 idle, 1 run, 2 stall, 3 halted; m_pc is the external PC register.
  int          m_mode;
  bit          m_pend, m_flush;
  logic [15:0] m_paddr, m_pc;
  // Expectations for the current cycle and the model's values after the next edge.
  bit          e_wr;
  logic [15:0] e_pc;
  int          n_mode;
  bit          n_pend, n_flush;
  logic [15:0] n_paddr;

  assign pc_out = m_pc;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_mode = 0; m_pend = 0; m_flush = 0; m_paddr = '0; m_pc = '0;
  endfunction

  // Decide what this cycle should do from the sequencing rules.
  function automatic void model_eval();
    bit redirect_now;
    e_wr = 0; e_pc = '0;
    n_mode = m_mode; n_pend = m_pend; n_paddr = m_paddr; n_flush = 0;
    redirect_now = jmp || br_taken;
    if (m_mode == 0) begin
      if (start) n_mode = 1;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (halt && !stall) begin
        n_mode = 3; n_pend = 0;
      end else if (stall) begin
        n_mode = 2;
        if (!m_pend && redirect_now) begin
          n_pend = 1;
          n_paddr = jmp ? jmp_target : br_target;
        end
      end else begin
        n_mode = 1; e_wr = 1;
        if (m_pend) begin
          e_pc = m_paddr; n_pend = 0; n_flush = 1;
        end else if (redirect_now) begin
          e_pc = jmp ? jmp_target : br_target; n_flush = 1;
        end else begin
          e_pc = 16'((32'(m_pc) + 2) % 65536);
        end
      end
    end
  endfunction

  // Apply inputs for one cycle and check all outputs against the model.
  task automatic drive(input bit st, input bit sl, input bit hl,
                       input bit bt, input logic [15:0] bta,
                       input bit jm, input logic [15:0] jta);
    start = st; stall = sl; halt = hl; br_taken = bt; br_target = bta; jmp = jm; jmp_target = jta;
    #1;
    model_eval();
    chk("state", 32'(state), 32'(m_mode));
    chk("redirect_pending", 32'(redirect_pending), 32'(m_pend));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("pc_write", 32'(pc_write), 32'(e_wr));
    if (e_wr || m_mode == 0) chk("pc_in", 32'(pc_in), 32'(e_pc));
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_wr) m_pc = e_pc;
    m_mode = n_mode; m_pend = n_pend; m_paddr = n_paddr; m_flush = n_flush;
    #1;
  endtask

  task automatic step(input bit st, input bit sl, input bit hl,
                      input bit bt, input logic [15:0] bta,
                      input bit jm, input logic [15:0] jta);
    drive(st, sl, hl, bt, bta, jm, jta);
    tick();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pending", 32'(redirect_pending), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Idle with no start, then start: no write in the start cycle.
    step(0, 0, 0, 0, 16'h0, 0, 16'h0);
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0);
    chk("start_no_write", 32'(pc_write), 32'd0);
    tick();

    // Sequential run from 0000.
    drive(0, 0, 0, 0, 16'h0, 0, 16'h0); chk("seq1", 32'(pc_in), 32'h0002); tick();
    drive(0, 0, 0, 0, 16'h0, 0, 16'h0); chk("seq2", 32'(pc_in), 32'h0004); tick();
    drive(0, 0, 0, 0, 16'h0, 0, 16'h0); chk("seq3", 32'(pc_in), 32'h0006); tick();

    // Jump beats branch in the same cycle.
    drive(0, 0, 0, 1, 16'h5678, 1, 16'h1234); chk("jmp_wins", 32'(pc_in), 32'h1234); tick();
    drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
    chk("jmp_flush", 32'(flush), 32'd1);
    chk("after_jmp", 32'(pc_in), 32'h1236);
    tick();
    drive(0, 0, 0, 0, 16'h0, 0, 16'h0); chk("flush_one_cycle", 32'(flush), 32'd0); tick();

    // Three-cycle stall: first redirect buffered, second ignored.
    step(0, 1, 0, 1, 16'h5678, 0, 16'h0);
    drive(0, 1, 0, 0, 16'h0, 1, 16'h9ABC);
    chk("stall_pending", 32'(redirect_pending), 32'd1);
    chk("stall_no_write", 32'(pc_write), 32'd0);
    tick();
    step(0, 1, 0, 0, 16'h0, 0, 16'h0);
    drive(0, 0, 0, 0, 16'h0, 1, 16'h4444);
    chk("release_target", 32'(pc_in), 32'h5678);
    tick();
    drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
    chk("release_flush", 32'(flush), 32'd1);
    chk("release_cleared", 32'(redirect_pending), 32'd0);
    tick();

    // Back-to-back redirects give back-to-back flushes; then wrap at FFFE.
    step(0, 0, 0, 1, 16'hFFFC, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0, 1, 16'hFFFE);
    drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
    chk("wrap", 32'(pc_in), 32'h0000);
    chk("b2b_flush", 32'(flush), 32'd1);
    tick();

    // halt is ignored under stall, then takes effect; halted ignores everything.
    step(0, 1, 1, 0, 16'h0, 0, 16'h0);
    chk("halt_under_stall", 32'(state), 32'd2);
    drive(0, 0, 1, 0, 16'h0, 0, 16'h0); chk("halt_no_write", 32'(pc_write), 32'd0); tick();
    chk("halted", 32'(state), 32'd3);
    step(1, 0, 0, 1, 16'h2222, 1, 16'h3333);
    drive(1, 0, 0, 0, 16'h0, 1, 16'h3333); chk("halted_ignores", 32'(pc_write), 32'd0); tick();

    // Reset mid-stall with a pending redirect.
    do_reset();
    step(1, 0, 0, 0, 16'h0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0, 0, 16'h0);
    step(0, 1, 0, 0, 16'h0, 1, 16'h0ABC);
    drive(0, 1, 0, 0, 16'h0, 0, 16'h0);
    chk("pend_before_rst", 32'(redirect_pending), 32'd1);
    do_reset();

    // Randomized episodes.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        if ($urandom % 97 == 0) do_reset();
        step(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 50) == 0,
             ($urandom % 4) == 0, 16'($urandom) & 16'hFFFE,
             ($urandom % 5) == 0, 16'($urandom) & 16'hFFFE);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Next-PC sequencer that drives the 16-bit PC register's pc_in/pc_write pair and observes its pc_out.
- Chooses sequential increment, branch or jump each cycle, and freezes the PC on stall or halt.
- Buffers one redirect that arrives during a stall and applies it on release.
- Sits between the decode/branch-resolve logic and the PC register; emits a flush pulse for the fetch/decode stages.

Parameters:
- ADDR_W, 16, width of PC and target addresses
- INC, 2, sequential increment in bytes (one 16-bit instruction)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  leave IDLE and begin sequencing
- stall  input  1  hold PC this cycle (hazard or memory wait)
- halt  input  1  stop sequencing permanently until reset
- br_taken  input  1  conditional branch resolved taken
- br_target  input  ADDR_W  branch destination
- jmp  input  1  unconditional jump
- jmp_target  input  ADDR_W  jump destination
- pc_out  input  ADDR_W  current value from PC register
- pc_in  output  ADDR_W  next PC value to PC register (combinational)
- pc_write  output  1  PC register write enable (combinational)
- flush  output  1  registered one-cycle pulse, cycle after a redirect write
- redirect_pending  output  1  registered; a buffered redirect is held
- state  output  2  FSM state: 0 IDLE, 1 RUN, 2 STALL, 3 HALTED

Behaviour:
- Reset (rst_n=0, async): state=IDLE, flush=0, redirect_pending=0, pend_addr=0.
- Reset effect on outputs: while in IDLE, pc_write=0 and pc_in=0.
- PC register reset is handled separately; its active-high rst is driven by ~rst_n at top level.
- IDLE: pc_write=0. start=1 -> RUN next cycle; no PC write in the start cycle.
- Active cycle = state RUN or STALL, with halt and stall evaluated combinationally.
- Active cycle priority order:
  1. halt=1 and stall=0: pc_write=0, pending discarded, next=HALTED.
  2. stall=1: pc_write=0, next=STALL.
     - If no pending redirect and (jmp or br_taken): latch target into pend_addr (jmp over br) and set redirect_pending.
     - If a redirect is already pending: the first captured redirect is kept and later ones are ignored.
     - halt is ignored while stall=1.
  3. stall=0 with redirect pending: pc_write=1, pc_in=pend_addr, clear pending, flush=1 next cycle, next=RUN.
     - Concurrent jmp/br_taken in this cycle are ignored.
  4. stall=0, jmp=1: pc_write=1, pc_in=jmp_target, flush next cycle, next=RUN.
  5. stall=0, br_taken=1: pc_write=1, pc_in=br_target, flush next cycle, next=RUN.
  6. Otherwise: pc_write=1, pc_in=pc_out+INC, next=RUN.
- Latency: zero; PC register captures pc_in on the same edge.
- Width rule: addition is modulo 2^ADDR_W; 16'hFFFE+2 wraps to 16'h0000 with no flag.
- HALTED: pc_write=0, all inputs ignored; exit only via rst_n.
- flush is exactly one cycle per applied redirect; back-to-back redirects give back-to-back flush cycles.
- Reset mid-stall with a pending redirect: pending lost, IDLE entered asynchronously.

Decomposition:
- Shared package holds:
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_STALL=2'd2, ST_HALTED=2'd3.
  - Default ADDR_W=16 and INC=2 constants, reused by the PC register and fetch logic.
- One sub-module: pc_redirect_buf, holding the single-entry pend_addr/redirect_pending buffer with capture/consume/clear controls.
- Next-state and output mux stay in pc_seq_ctrl.

Test Plan:
- Reset then start, pc_out tracks writes from 0000: pc_in sequence 0002, 0004, 0006, pc_write=1 each cycle, flush=0.
- jmp=1, jmp_target=1234, with br_taken=1, br_target=5678, same cycle: pc_in=1234 (jump wins), flush=1 exactly one cycle later; next cycle pc_in=1236.
- Stall for 3 cycles; during the first stall cycle br_taken=1, br_target=5678; during the second jmp=1, jmp_target=9ABC:
  - Required while stalled: pc_write=0, redirect_pending=1.
  - Required on release: pc_in=5678, flush pulse, pending cleared.
- pc_out=FFFE, no redirect: pc_in=0000.
- halt=1 together with stall=1: remains STALL. halt=1 after stall drops: pc_write=0, state=3, later jmp/start ignored.
- Assert rst_n=0 asynchronously mid-clock while redirect pending: state=0, redirect_pending=0, flush=0 immediately, before the next edge.
